// File: rtl/i2c_lcd_target.sv
`default_nettype none
// ============================================================================
// Module  : i2c_lcd_target
// Brief   : I2C target exposing an 8-bit parallel port (LCD backpack style).
// Rev     : 1.0  initial release
// ============================================================================
module i2c_lcd_target #(
    parameter logic [6:0] I2C_ADDR  = 7'h27,
    parameter logic [7:0] PORT_INIT = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] port_in,
    output logic [7:0] port_out,
    output logic       byte_valid,
    output logic       busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_WR_DATA   = 3'd3;
    localparam logic [2:0] S_WR_ACK    = 3'd4;
    localparam logic [2:0] S_RD_DATA   = 3'd5;
    localparam logic [2:0] S_RD_ACK    = 3'd6;
    localparam logic [2:0] S_WAIT_STOP = 3'd7;

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_d;
    logic       r_sda_d;
    logic [2:0] r_state;
    logic [7:0] r_shift;
    logic [3:0] r_bit_cnt;

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_shift_in;

    // Synchronizers idle high so a reset never looks like a bus condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_in};
            r_sda_sync <= {r_sda_sync[0], sda_in};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_shift_in = {r_shift[6:0], w_sda};

    // In the ACK states sda_oe doubles as the phase flag: low = ACK not yet driven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= 8'h00;
            r_bit_cnt  <= 4'd0;
            sda_oe     <= 1'b0;
            port_out   <= PORT_INIT;
            byte_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (w_start) begin
                r_state   <= S_ADDR;
                r_shift   <= 8'h00;
                r_bit_cnt <= 4'd0;
                sda_oe    <= 1'b0;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 4'd0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_shift_in;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= 4'd0;
                                if (w_shift_in[7:1] == I2C_ADDR) begin
                                    r_state <= S_ADDR_ACK;
                                    busy    <= 1'b1;
                                end else begin
                                    r_state <= S_WAIT_STOP;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end

                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else if (r_shift[0]) begin
                                r_state   <= S_RD_DATA;
                                r_shift   <= port_in;
                                sda_oe    <= ~port_in[7];
                                r_bit_cnt <= 4'd0;
                            end else begin
                                r_state   <= S_WR_DATA;
                                sda_oe    <= 1'b0;
                                r_bit_cnt <= 4'd0;
                            end
                        end
                    end

                    S_WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift <= w_shift_in;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_WR_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end

                    S_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe     <= 1'b1;
                                port_out   <= r_shift;
                                byte_valid <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                r_state <= S_WR_DATA;
                            end
                        end
                    end

                    // r_shift[7] is always the bit currently on the bus.
                    S_RD_DATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                sda_oe    <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_RD_ACK;
                            end else begin
                                r_shift <= {r_shift[6:0], 1'b0};
                                sda_oe  <= ~r_shift[6];
                            end
                        end
                    end

                    // r_bit_cnt == 1 marks an ACK seen on the rise, awaiting the fall.
                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) begin
                                r_state <= S_WAIT_STOP;
                            end else begin
                                r_bit_cnt <= 4'd1;
                            end
                        end else if (w_scl_fall && (r_bit_cnt == 4'd1)) begin
                            r_state   <= S_RD_DATA;
                            r_shift   <= port_in;
                            sda_oe    <= ~port_in[7];
                            r_bit_cnt <= 4'd0;
                        end
                    end

                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/i2c_lcd_target.md
I2C_LCD_TARGET -- requirements
Module: i2c_lcd_target

Interface
REQ-001 Parameter I2C_ADDR, default 7'h27, 7-bit target address the block answers.
REQ-002 Parameter PORT_INIT, default 8'hFF, port_out value after reset.
REQ-003 clk  input  1  system clock, at least 16x the SCL rate.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 scl_in  input  1  raw I2C SCL line level.
REQ-006 sda_in  input  1  raw I2C SDA line level.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release.
REQ-008 port_in  input  8  parallel value returned on I2C reads.
REQ-009 port_out  output  8  last data byte written by the I2C initiator.
REQ-010 byte_valid  output  1  one-clk pulse per accepted write byte.
REQ-011 busy  output  1  high from an address-matched START until STOP.

Function
REQ-012 scl_in and sda_in SHALL each pass a 2-flop synchronizer; all edge detection uses the synchronized values and their 1-clk-delayed copies.
REQ-013 START = synchronized SDA falls while SCL is high; STOP = SDA rises while SCL is high; both detected in any state.
REQ-014 States SHALL be IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-015 START in any state (including repeated START) -> ADDR, bit counter cleared, sda_oe released.
REQ-016 STOP in any state -> IDLE, sda_oe = 0, busy = 0.
REQ-017 Data bits SHALL be sampled MSB-first on SCL rising edges; sda_oe SHALL only change on SCL falling edges (or START/STOP/reset).
REQ-018 ADDR: after 8 bits, if bits[7:1] == I2C_ADDR -> ADDR_ACK, busy = 1; else -> WAIT_STOP, no ACK.
REQ-019 ADDR_ACK: sda_oe = 1 from the next SCL fall to the following SCL fall; then R/W bit 0 -> WR_DATA, 1 -> RD_DATA.
REQ-020 WR_DATA: after 8 bits -> WR_ACK; on the SCL fall starting the ACK, port_out <= received byte and byte_valid pulses for exactly one clk.
REQ-021 WR_ACK: sda_oe = 1 for one SCL low/high period, then -> WR_DATA for the next byte; unbounded byte count per transaction.
REQ-022 RD_DATA: port_in SHALL be captured into the shift register on the SCL fall ending the preceding ACK; sda_oe = ~current bit, MSB first.
REQ-023 After the 8th read bit, sda_oe released on SCL fall -> RD_ACK; initiator bit sampled on next SCL rise: 0 -> RD_DATA (fresh port_in capture), 1 -> WAIT_STOP.
REQ-024 WAIT_STOP: sda_oe = 0, ignore SCL activity until START or STOP.
REQ-025 SDA changes while SCL is high other than START/STOP conditions SHALL NOT occur in any non-IDLE data phase except as START/STOP.
REQ-026 byte_valid SHALL never pulse for address bytes, mismatched addresses, or a partial byte cut by START/STOP.
REQ-027 A partial byte aborted by START/STOP SHALL leave port_out unchanged.

Reset
REQ-028 On rst: state = IDLE, sda_oe = 0, port_out = PORT_INIT, byte_valid = 0, busy = 0, shift register and bit counter = 0, synchronizers = 1.
REQ-029 rst asserted mid-transaction SHALL release SDA immediately (asynchronous) and the block SHALL ignore the bus until the next START.

Verification
REQ-030 Write 0x4E (addr 0x27, W), data 0x3C, STOP -> sda_oe asserted in both ACK slots, port_out = 0x3C, one byte_valid pulse, busy 1 then 0.
REQ-031 Address 0x4C (addr 0x26) then 8 data bits -> sda_oe never asserted, port_out stays 0xFF, no byte_valid.
REQ-032 Read 0x4F with port_in = 0xA5, initiator ACK, second byte with port_in = 0x5A, NACK, STOP -> bus bits 10100101 then 01011010, SDA released at NACK.
REQ-033 Write 0x4E, data 0x08, 0x0C, 0x08 -> port_out sequence 0x08, 0x0C, 0x08, three byte_valid pulses.
REQ-034 Write 0x4E, 4 data bits of 0xF0, repeated START, 0x4F read -> port_out unchanged, read byte returns port_in.
REQ-035 rst pulse while sda_oe = 1 during ACK -> sda_oe = 0 same cycle, state IDLE, port_out = 0xFF.
